// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with one-entry skid buffer and flush
// Optional stall/flush counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W     = 16,
  parameter int NUM_FIELDS = 3,
  parameter int CTRL_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CTRL_W-1:0]              r_main_ctrl;
  logic [NUM_FIELDS*DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]              r_skid_ctrl;
  logic [NUM_FIELDS*DATA_W-1:0]   r_skid_data;
  logic                           w_in_xfer;
  logic                           w_out_xfer;
  logic                           w_load_main_in;
  logic                           w_load_main_skid;
  logic                           w_load_skid;

  // Outputs come from registered state; rst only masks them so a bubble is visible during reset.
  assign in_ready   = rst || (r_state != S_FULL);
  assign out_valid  = !rst && (r_state != S_EMPTY);
  assign occupancy  = rst ? 2'd0 : r_state;
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign out_data   = rst ? '0 : r_main_data;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating counters; flushes of an already-empty stage are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
`endif

endmodule
